// File: rtl/aes_pkg.sv
// Shared definitions for the AES issue controller and its neighbours at the top level.
// Holds the controller FSM encoding, the slot round-state codes and the pipeline depth.
// No logic of its own apart from a small slot-decoding helper.
package aes_pkg;

    // Controller FSM encoding
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_KEY = 2'd1,
        RUN      = 2'd2,
        DRAIN    = 2'd3
    } aes_state_e;

    // Round state reported by a slot that has finished its last round
    localparam logic [4:0] ST_DONE      = 5'b11010;
    // Slot state bit that marks the slot as holding a block
    localparam int         ST_VALID_BIT = 4;
    // Number of slots in the encryption pipeline
    localparam int         MAX_INFLIGHT = 3;

    // A slot can accept a new block when it is empty or its block is leaving this cycle
    function automatic logic slot_free(input logic [4:0] slot_state);
        return (!slot_state[ST_VALID_BIT]) || (slot_state == ST_DONE);
    endfunction

endpackage

// File: rtl/aes_issue_controller.sv
// Issues plaintext blocks into the AES pipeline and writes finished blocks out.
// Latency: read_fifo/stall/out_write are combinational from the returning slot; counters update next edge.
// Backpressure: out_full on a DONE slot freezes the pipeline (stall) and blocks both issue and write.
module aes_issue_controller #(
    parameter int CNT_W        = 16,
    parameter int MAX_INFLIGHT = aes_pkg::MAX_INFLIGHT
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             stop,
    input  logic             key_ready,
    input  logic             in_empty,
    input  logic             out_full,
    input  logic [4:0]       slot_state,
    output logic             read_fifo,
    output logic             stall,
    output logic             out_write,
    output logic [1:0]       in_flight,
    output logic             busy,
    output logic [CNT_W-1:0] done_count,
    output logic             key_err
);
    import aes_pkg::*;

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_WAIT_KEY = WAIT_KEY;
    localparam logic [1:0] S_RUN      = RUN;
    localparam logic [1:0] S_DRAIN    = DRAIN;

    localparam logic [1:0] MAX_CNT = 2'(MAX_INFLIGHT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       key_ready_q;
    logic       slot_done;
    logic       free;

    assign slot_done = (slot_state == ST_DONE);
    assign free      = slot_free(slot_state);

    // Freeze the pipeline while a finished block cannot be written out
    assign stall     = out_full & slot_done;

    // Held low during reset so abandoned blocks never reach the output buffer
    assign out_write = n_rst & slot_done & ~out_full;

    // Issue only while running with a stable key, data available and a slot to put it in
    assign read_fifo = (state == S_RUN) & key_ready & ~in_empty & free & ~stall;

    assign busy      = (state != S_IDLE);

    // Next-state decode; stop always beats start
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !stop)
                    state_nxt = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                if (stop)
                    state_nxt = S_DRAIN;
                else if (key_ready)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop)
                    state_nxt = S_DRAIN;
                else if (!key_ready)
                    state_nxt = S_WAIT_KEY;
            end
            S_DRAIN: begin
                if ((in_flight == 2'd0) && !read_fifo)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Occupancy: a recycled slot (issue and write together) leaves the count unchanged
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            in_flight <= 2'd0;
        else if (read_fifo && !out_write) begin
            if (in_flight < MAX_CNT)
                in_flight <= in_flight + 2'd1;
        end else if (out_write && !read_fifo) begin
            if (in_flight != 2'd0)
                in_flight <= in_flight - 2'd1;
        end
    end

    // Completed-block counter, wraps naturally at full scale
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            done_count <= '0;
        else if (out_write)
            done_count <= done_count + CNT_W'(1);
    end

    // Sticky flag for the key being withdrawn while blocks are still in the pipeline
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_ready_q <= 1'b0;
            key_err     <= 1'b0;
        end else begin
            key_ready_q <= key_ready;
            if (key_ready_q && !key_ready && (in_flight != 2'd0))
                key_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_issue_controller.sv
// Self-checking bench for aes_issue_controller.
// Combinational decode is checked from a vector table with the clock held; sequences cover the FSM.
// Expected values are hand-derived constants.
module tb_aes_issue_controller;

    logic        clk = 1'b0;
    bit          clk_en = 1'b1;
    logic        n_rst;
    logic        start;
    logic        stop;
    logic        key_ready;
    logic        in_empty;
    logic        out_full;
    logic [4:0]  slot_state;
    logic        read_fifo;
    logic        stall;
    logic        out_write;
    logic [1:0]  in_flight;
    logic        busy;
    logic [15:0] done_count;
    logic        key_err;

    int tests  = 0;
    int failed = 0;

    localparam logic [4:0] S_EMPTY = 5'b00000;
    localparam logic [4:0] S_BUSY  = 5'b10001;
    localparam logic [4:0] S_DONE  = 5'b11010;

    aes_issue_controller #(.CNT_W(16), .MAX_INFLIGHT(3)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .stop       (stop),
        .key_ready  (key_ready),
        .in_empty   (in_empty),
        .out_full   (out_full),
        .slot_state (slot_state),
        .read_fifo  (read_fifo),
        .stall      (stall),
        .out_write  (out_write),
        .in_flight  (in_flight),
        .busy       (busy),
        .done_count (done_count),
        .key_err    (key_err)
    );

    // Clock can be parked low so combinational vectors see no edges
    always #5 clk = clk_en ? ~clk : 1'b0;

    typedef struct {
        logic [4:0] slot;
        logic       ofull;
        logic       iempty;
        logic       kready;
        logic [2:0] exp_rsw;   // {read_fifo, stall, out_write}
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        key_ready  = 1'b0;
        in_empty   = 1'b1;
        out_full   = 1'b1;
        slot_state = S_DONE;
        #1;
        check("rst_stall",     32'(stall), 32'd1);
        out_full = 1'b0;
        #1;
        check("rst_out_write", 32'(out_write), 32'd0);
        check("rst_read",      32'(read_fifo), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_in_flight", 32'(in_flight), 32'd0);
        check("rst_done",      32'(done_count), 32'd0);
        check("rst_key_err",   32'(key_err), 32'd0);
        slot_state = S_EMPTY;
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    initial begin
        vecs[0] = '{S_EMPTY,    1'b0, 1'b0, 1'b1, 3'b100};
        vecs[1] = '{S_DONE,     1'b0, 1'b0, 1'b1, 3'b101};
        vecs[2] = '{S_DONE,     1'b1, 1'b0, 1'b1, 3'b010};
        vecs[3] = '{S_BUSY,     1'b0, 1'b0, 1'b1, 3'b000};
        vecs[4] = '{S_BUSY,     1'b1, 1'b0, 1'b1, 3'b000};
        vecs[5] = '{S_EMPTY,    1'b0, 1'b1, 1'b1, 3'b000};
        vecs[6] = '{S_EMPTY,    1'b0, 1'b0, 1'b0, 3'b000};
        vecs[7] = '{5'b01010,   1'b1, 1'b0, 1'b1, 3'b100};
        vecs[8] = '{S_DONE,     1'b0, 1'b1, 1'b1, 3'b001};
        vecs[9] = '{S_DONE,     1'b1, 1'b0, 1'b0, 3'b010};

        do_reset();

        // Start-up: three issues into empty slots
        key_ready = 1'b1;
        in_empty  = 1'b0;
        start     = 1'b1;
        #1;
        check("idle_read", 32'(read_fifo), 32'd0);
        tick();
        start = 1'b0;
        #1;
        check("waitkey_busy", 32'(busy), 32'd1);
        check("waitkey_read", 32'(read_fifo), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("fill_read", 32'(read_fifo), 32'd1);
            tick();
            check("fill_in_flight", 32'(in_flight), 32'(i + 1));
        end
        slot_state = S_BUSY;
        #1;
        check("full_read", 32'(read_fifo), 32'd0);
        check("full_busy", 32'(busy), 32'd1);

        // Output backpressure for four cycles
        slot_state = S_DONE;
        out_full   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_stall", 32'(stall), 32'd1);
            check("bp_write", 32'(out_write), 32'd0);
            tick();
        end
        check("bp_done_hold",  32'(done_count), 32'd0);
        check("bp_inflt_hold", 32'(in_flight), 32'd3);
        out_full = 1'b0;
        in_empty = 1'b1;
        #1;
        check("release_write", 32'(out_write), 32'd1);
        check("release_stall", 32'(stall), 32'd0);
        check("release_read",  32'(read_fifo), 32'd0);
        tick();
        check("release_done",  32'(done_count), 32'd1);
        check("release_inflt", 32'(in_flight), 32'd2);

        // Slot recycled: issue and write in the same cycle
        in_empty = 1'b0;
        #1;
        check("recycle_read",  32'(read_fifo), 32'd1);
        check("recycle_write", 32'(out_write), 32'd1);
        tick();
        check("recycle_inflt", 32'(in_flight), 32'd2);
        check("recycle_done",  32'(done_count), 32'd2);

        // Combinational decode table in RUN with the clock parked
        slot_state = S_BUSY;
        @(negedge clk);
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            slot_state = vecs[i].slot;
            out_full   = vecs[i].ofull;
            in_empty   = vecs[i].iempty;
            key_ready  = vecs[i].kready;
            #1;
            check($sformatf("vec%0d_rsw", i), 32'({read_fifo, stall, out_write}), 32'(vecs[i].exp_rsw));
        end
        slot_state = S_BUSY;
        out_full   = 1'b0;
        in_empty   = 1'b0;
        key_ready  = 1'b1;
        #1;
        clk_en = 1'b1;
        tick();
        check("table_inflt", 32'(in_flight), 32'd2);

        // Stop with two blocks in flight
        stop = 1'b1;
        tick();
        stop = 1'b0;
        slot_state = S_DONE;
        #1;
        check("drain_busy",  32'(busy), 32'd1);
        check("drain_read",  32'(read_fifo), 32'd0);
        check("drain_write", 32'(out_write), 32'd1);
        tick();
        check("drain_inflt1", 32'(in_flight), 32'd1);
        tick();
        slot_state = S_EMPTY;
        #1;
        check("drain_inflt0", 32'(in_flight), 32'd0);
        check("drain_done",   32'(done_count), 32'd4);
        check("drain_read_empty", 32'(read_fifo), 32'd0);
        tick();
        check("drain_idle", 32'(busy), 32'd0);

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        #1;
        check("startstop_idle", 32'(busy), 32'd0);

        // stop in WAIT_KEY goes straight to DRAIN, then IDLE
        key_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("wk_busy", 32'(busy), 32'd1);
        check("wk_read", 32'(read_fifo), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        #1;
        check("wk_drain_busy", 32'(busy), 32'd1);
        tick();
        check("wk_drain_idle", 32'(busy), 32'd0);
        check("wk_no_key_err", 32'(key_err), 32'd0);

        // Key withdrawn with one block in flight
        key_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ke_read", 32'(read_fifo), 32'd1);
        tick();
        slot_state = S_BUSY;
        #1;
        check("ke_inflt1", 32'(in_flight), 32'd1);
        key_ready  = 1'b0;
        slot_state = S_EMPTY;
        #1;
        check("ke_read_off", 32'(read_fifo), 32'd0);
        tick();
        check("ke_err_set", 32'(key_err), 32'd1);
        check("ke_busy",    32'(busy), 32'd1);
        slot_state = S_DONE;
        #1;
        check("ke_write", 32'(out_write), 32'd1);
        tick();
        slot_state = S_EMPTY;
        in_empty   = 1'b1;
        key_ready  = 1'b1;
        #1;
        check("ke_inflt0", 32'(in_flight), 32'd0);
        check("ke_done",   32'(done_count), 32'd5);
        repeat (3) tick();
        check("ke_sticky", 32'(key_err), 32'd1);
        do_reset();
        check("ke_cleared", 32'(key_err), 32'd0);

        // Counter wrap at full scale
        slot_state = S_DONE;
        out_full   = 1'b0;
        repeat (65535) tick();
        check("wrap_max",   32'(done_count), 32'h0000_FFFF);
        check("wrap_inflt", 32'(in_flight), 32'd0);
        tick();
        check("wrap_zero",  32'(done_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/aes_issue_controller.md
AES_ISSUE_CONTROLLER -- requirements
Module: aes_issue_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-block counter.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 3, equal to the number of pipeline slots.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin issuing blocks.
REQ-006 stop  input  1  one-cycle request to stop issuing and drain the pipeline.
REQ-007 key_ready  input  1  round-key store is loaded and stable.
REQ-008 in_empty  input  1  input plaintext FIFO is empty.
REQ-009 out_full  input  1  output ciphertext buffer cannot accept a word.
REQ-010 slot_state  input  5  round state of the slot returning to data select: bit4 = valid; 5'b11010 = DONE.
REQ-011 read_fifo  output  1  pop input FIFO and load this slot into the pipeline.
REQ-012 stall  output  1  freeze all pipeline registers; drives the pipeline's is_full.
REQ-013 out_write  output  1  push the current pipeline output word into the output buffer.
REQ-014 in_flight  output  2  number of blocks currently in the pipeline (0..3).
REQ-015 busy  output  1  FSM is not IDLE.
REQ-016 done_count  output  CNT_W  completed-block count.
REQ-017 key_err  output  1  sticky error flag.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_KEY, RUN and DRAIN.
REQ-019 FSM transitions SHALL be:
- IDLE to WAIT_KEY on start.
- WAIT_KEY to RUN when key_ready=1.
- RUN to DRAIN on stop.
- DRAIN to IDLE when in_flight=0 and read_fifo=0.
- RUN to WAIT_KEY when key_ready=0.
- start outside IDLE SHALL be ignored.
REQ-020 A slot SHALL be free when slot_state[4]=0 or slot_state=5'b11010.
REQ-021 stall SHALL be combinational: stall = out_full AND (slot_state = 5'b11010).
REQ-022 read_fifo SHALL be combinational: read_fifo = (state=RUN) AND key_ready AND !in_empty AND slot free AND !stall.
REQ-023 out_write SHALL be combinational: out_write = (slot_state = 5'b11010) AND !out_full.
- Each DONE slot SHALL produce exactly one out_write.
REQ-024 in_flight SHALL update each cycle as follows:
- +1 on read_fifo alone.
- -1 on out_write alone.
- Unchanged when both are asserted (slot recycled in the same cycle).
- Saturating bounds 0..MAX_INFLIGHT.
REQ-025 done_count SHALL increment by 1 on each out_write and wrap from 2^CNT_W-1 to 0.
REQ-026 stop in WAIT_KEY SHALL go directly to DRAIN.
REQ-027 start and stop asserted in the same cycle SHALL be resolved in favour of stop.
REQ-028 key_err SHALL set when key_ready falls while in_flight is nonzero.
- It SHALL clear only on reset.
- Issuing stops (RUN to WAIT_KEY); in-flight blocks SHALL still complete and be written.
REQ-029 In DRAIN and WAIT_KEY, read_fifo SHALL be 0; stall and out_write SHALL still operate.
REQ-030 No block SHALL be lost or duplicated across any stall, stop or WAIT_KEY sequence.

Reset
REQ-031 On n_rst=0, asynchronously:
- FSM SHALL be IDLE.
- in_flight=0, done_count=0, key_err=0.
- Outputs SHALL be busy=0, read_fifo=0, out_write=0.
- stall SHALL follow REQ-021.
REQ-032 Reset mid-operation SHALL abandon in-flight blocks without generating out_write.

Structure
REQ-033 A shared aes_pkg SHALL hold:
- The FSM state enum.
- Constants ST_DONE=5'b11010 and ST_VALID_BIT=4.
- MAX_INFLIGHT.
REQ-034 The block SHALL be one module with no sub-modules; it sits beside the AES encryption pipeline at the top level.

Verification
REQ-035 Reset, then start, with key_ready=1 and in_empty=0: read_fifo SHALL be high on the first 3 free slots, in_flight SHALL reach 3, and busy=1.
REQ-036 Slot returns 5'b11010 with out_full=1 for 4 cycles: stall=1 and out_write=0 for 4 cycles; then out_full=0 gives one out_write and done_count +1.
REQ-037 DONE slot with out_full=0 and in_empty=0 in RUN: read_fifo=1 and out_write=1 in the same cycle, with in_flight unchanged.
REQ-038 stop with in_flight=2: no further read_fifo; after 2 out_writes, busy SHALL fall and the FSM SHALL be IDLE.
REQ-039 key_ready falls with in_flight=1: key_err=1 and read_fifo=0; the block still completes; key_err SHALL stay 1 until reset.
REQ-040 Preload done_count=16'hFFFF (CNT_W=16), then one out_write: done_count=0.
